// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register of the multistage MIPS datapath. It sits right
//   after the data memory and captures the load result, the ALU result, the
//   destination register and the write-back controls. It drives the selected
//   write-back value to the register file and to the forwarding unit.
//   Supports stall (hold), flush (bubble) and keeps saturating counters of
//   retired instructions and retired loads.
//
// Parameters
//   DW  datapath width (dm_out, mem_alu_out, wb_data)
//   RW  register-index width
//   CW  width of each performance counter
//
// Ports
//   clock         in   1   rising-edge clock
//   reset_n       in   1   asynchronous active-low reset
//   stall         in   1   hold all state
//   flush         in   1   insert a bubble
//   mem_valid     in   1   MEM stage holds a real instruction
//   dm_out        in   DW  load data from data memory
//   mem_alu_out   in   DW  ALU result from EX/MEM
//   mem_rd        in   RW  destination register index
//   mem_RegWrite  in   1   instruction writes the register file
//   mem_MemtoReg  in   1   1 = write back load data, 0 = ALU result
//   clr_cnt       in   1   synchronous clear of both counters
//   wb_valid      out  1   WB stage holds a real instruction
//   wb_RegWrite   out  1   register-file write enable
//   wb_rd         out  RW  register-file write index
//   wb_data       out  DW  write-back value
//   fwd_en        out  1   forwarding source valid (write to a non-zero reg)
//   retired_cnt   out  CW  instructions that left WB
//   load_cnt      out  CW  loads that left WB
// -----------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic [DW-1:0] dm_out,
  input  logic [DW-1:0] mem_alu_out,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_RegWrite,
  input  logic          mem_MemtoReg,
  input  logic          clr_cnt,
  output logic          wb_valid,
  output logic          wb_RegWrite,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          fwd_en,
  output logic [CW-1:0] retired_cnt,
  output logic [CW-1:0] load_cnt
);

  logic          r_valid;
  logic          r_regwrite;
  logic          r_memtoreg;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_dm;
  logic [DW-1:0] r_alu;
  logic [CW-1:0] r_retired;
  logic [CW-1:0] r_loads;

  // The instruction currently in WB moves on at this edge.
  logic          w_leave;
  logic          w_retired_max;
  logic          w_loads_max;

  assign w_leave       = r_valid & ~stall;
  assign w_retired_max = &r_retired;
  assign w_loads_max   = &r_loads;

  // Pipeline register. A flush clears only the control fields; the data
  // registers keep their old contents since nothing qualifies them anymore.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rd       <= '0;
      r_dm       <= '0;
      r_alu      <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rd       <= '0;
    end else if (!stall) begin
      r_valid    <= mem_valid;
      // A bubble carrying a stale RegWrite must never write.
      r_regwrite <= mem_RegWrite & mem_valid;
      r_memtoreg <= mem_MemtoReg;
      r_rd       <= mem_rd;
      r_dm       <= dm_out;
      r_alu      <= mem_alu_out;
    end
  end

  // Saturating performance counters; clear wins over increment and is
  // honoured even while stalled. Flush has no effect here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= '0;
      r_loads   <= '0;
    end else if (clr_cnt) begin
      r_retired <= '0;
      r_loads   <= '0;
    end else if (w_leave) begin
      if (!w_retired_max) begin
        r_retired <= r_retired + CW'(1);
      end
      if (r_memtoreg && !w_loads_max) begin
        r_loads <= r_loads + CW'(1);
      end
    end
  end

  assign wb_valid    = r_valid;
  assign wb_RegWrite = r_regwrite & r_valid;
  assign wb_rd       = r_rd;
  assign wb_data     = r_memtoreg ? r_dm : r_alu;
  assign fwd_en      = wb_RegWrite & (r_rd != '0);
  assign retired_cnt = r_retired;
  assign load_cnt    = r_loads;

endmodule
